qspi_mem_ctrl: RTL and testbench

QSPI_MEM_CTRL -- requirements
Module: qspi_mem_ctrl

---
 rtl/qspi_pkg.sv | 26 ++
 rtl/qspi_shift_reg.sv | 28 ++
 rtl/qspi_mem_ctrl.sv | 227 ++++++++++++++++++++++
 tb/tb_qspi_mem_ctrl.sv | 319 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/qspi_pkg.sv
// rtl/qspi_pkg.sv - shared states, opcodes and phase lengths for the QSPI memory controller
package qspi_pkg;

   localparam logic [2:0] ST_IDLE  = 3'd0;
   localparam logic [2:0] ST_CMD   = 3'd1;
   localparam logic [2:0] ST_ADDR  = 3'd2;
   localparam logic [2:0] ST_DUMMY = 3'd3;
   localparam logic [2:0] ST_DATA  = 3'd4;
   localparam logic [2:0] ST_GAP   = 3'd5;

   localparam int CMD_SCLKS  = 8;
   localparam int ADDR_SCLKS = 6;
   localparam int DATA_SCLKS = 8;
   localparam int GAP_CLKS   = 2;

   localparam int         DEF_DUMMY_CYCLES = 6;
   localparam logic [7:0] DEF_FLASH_RD_CMD = 8'hEB;
   localparam logic [7:0] DEF_RAM_RD_CMD   = 8'hEB;
   localparam logic [7:0] DEF_RAM_WR_CMD   = 8'h38;

   // Wire order is byte0 first; the shifter runs MSB first, so words are byte-reversed.
   function automatic logic [31:0] byte_swap(input logic [31:0] w);
      return {w[7:0], w[15:8], w[23:16], w[31:24]};
   endfunction

endpackage

// File: rtl/qspi_shift_reg.sv
// rtl/qspi_shift_reg.sv - 32-bit MSB-first shifter, 1-bit or 4-bit per step
module qspi_shift_reg (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        i_load,
   input  logic [31:0] i_load_data,
   input  logic        i_shift,
   input  logic        i_quad,
   input  logic [3:0]  i_in,
   output logic [31:0] o_q
);

   logic [31:0] r_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_q <= '0;
      end else if (i_load) begin
         r_q <= i_load_data;
      end else if (i_shift) begin
         if (i_quad) r_q <= {r_q[27:0], i_in};
         else        r_q <= {r_q[30:0], i_in[0]};
      end
   end

   assign o_q = r_q;

endmodule

// File: rtl/qspi_mem_ctrl.sv
// rtl/qspi_mem_ctrl.sv - quad-SPI controller sharing one bus between flash and PSRAM
// Define QSPI_PSRAM_WRITE_EN to enable PSRAM writes; otherwise every write is rejected.
module qspi_mem_ctrl
   import qspi_pkg::*;
#(
   parameter int         DUMMY_CYCLES = DEF_DUMMY_CYCLES,
   parameter logic [7:0] FLASH_RD_CMD = DEF_FLASH_RD_CMD,
   parameter logic [7:0] RAM_RD_CMD   = DEF_RAM_RD_CMD,
   parameter logic [7:0] RAM_WR_CMD   = DEF_RAM_WR_CMD
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_sel,
   input  logic        req_we,
   input  logic [23:0] req_addr,
   input  logic [31:0] req_wdata,
   output logic        rsp_valid,
   output logic        rsp_err,
   output logic [31:0] rsp_rdata,
   output logic        flash_cs_n,
   output logic        ram_cs_n,
   output logic        bus_sclk,
   output logic [3:0]  bus_io_out,
   output logic [3:0]  bus_io_oe,
   input  logic [3:0]  bus_io_in
);

   localparam logic [7:0] CNT_CMD   = 8'(CMD_SCLKS - 1);
   localparam logic [7:0] CNT_ADDR  = 8'(ADDR_SCLKS - 1);
   localparam logic [7:0] CNT_DATA  = 8'(DATA_SCLKS - 1);
   localparam logic [7:0] CNT_DUMMY = 8'(DUMMY_CYCLES - 1);
   localparam logic [7:0] CNT_GAP   = 8'(GAP_CLKS - 1);

   logic [2:0]  r_state;
   logic [7:0]  r_cnt;
   logic        r_sclk;
   logic        r_flash_cs_n;
   logic        r_ram_cs_n;
   logic        r_we;
   logic [23:0] r_addr;
   logic        r_rdy_en;
   logic        r_rsp_valid;
   logic        r_rsp_err;
   logic [31:0] r_rsp_rdata;
`ifdef QSPI_PSRAM_WRITE_EN
   logic [31:0] r_wdata;
`else
   logic        w_unused_wdata;
`endif

   logic        w_accept;
   logic        w_reject;
   logic        w_active;
   logic        w_tick;
   logic        w_last;
   logic        w_load;
   logic        w_shift;
   logic        w_quad;
   logic [31:0] w_load_data;
   logic [31:0] w_shq;
   logic [7:0]  w_cmd;

   assign req_ready = r_rdy_en && (r_state == ST_IDLE);
   assign w_accept  = req_valid && req_ready;
`ifdef QSPI_PSRAM_WRITE_EN
   assign w_reject  = req_we && !req_sel;
`else
   assign w_reject  = req_we;
   assign w_unused_wdata = ^req_wdata;
`endif
   assign w_active  = (r_state == ST_CMD) || (r_state == ST_ADDR) ||
                      (r_state == ST_DUMMY) || (r_state == ST_DATA);
   // A tick is the clk edge ending SCLK phase 1: sample point and advance point.
   assign w_tick    = w_active && r_sclk;
   assign w_last    = (r_cnt == 8'd0);
   assign w_quad    = (r_state != ST_CMD);
   assign w_cmd     = req_sel ? (req_we ? RAM_WR_CMD : RAM_RD_CMD) : FLASH_RD_CMD;

   always_comb begin
      w_load      = 1'b0;
      w_load_data = '0;
      w_shift     = 1'b0;
      if (w_accept && !w_reject) begin
         w_load      = 1'b1;
         w_load_data = {w_cmd, 24'h0};
      end else if (w_tick) begin
         if (r_state == ST_DATA) begin
            w_shift = 1'b1;
         end else if (!w_last) begin
            w_shift = (r_state == ST_CMD) || (r_state == ST_ADDR);
         end else if (r_state == ST_CMD) begin
            w_load      = 1'b1;
            w_load_data = {r_addr, 8'h0};
         end
`ifdef QSPI_PSRAM_WRITE_EN
         else if ((r_state == ST_ADDR) && r_we) begin
            w_load      = 1'b1;
            w_load_data = byte_swap(r_wdata);
         end
`endif
      end
   end

   qspi_shift_reg u_shift (
      .clk         (clk),
      .rst_n       (rst_n),
      .i_load      (w_load),
      .i_load_data (w_load_data),
      .i_shift     (w_shift),
      .i_quad      (w_quad),
      .i_in        (bus_io_in),
      .o_q         (w_shq)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state      <= ST_IDLE;
         r_cnt        <= '0;
         r_sclk       <= 1'b0;
         r_flash_cs_n <= 1'b1;
         r_ram_cs_n   <= 1'b1;
         r_we         <= 1'b0;
         r_addr       <= '0;
         r_rdy_en     <= 1'b0;
         r_rsp_valid  <= 1'b0;
         r_rsp_err    <= 1'b0;
         r_rsp_rdata  <= '0;
`ifdef QSPI_PSRAM_WRITE_EN
         r_wdata      <= '0;
`endif
      end else begin
         r_rdy_en    <= 1'b1;
         r_rsp_valid <= 1'b0;
         r_rsp_err   <= 1'b0;
         case (r_state)
            ST_IDLE: begin
               if (w_accept) begin
                  r_we   <= req_we;
                  r_addr <= req_addr;
`ifdef QSPI_PSRAM_WRITE_EN
                  r_wdata <= req_wdata;
`endif
                  if (w_reject) begin
                     r_rsp_valid <= 1'b1;
                     r_rsp_err   <= 1'b1;
                  end else begin
                     r_state      <= ST_CMD;
                     r_cnt        <= CNT_CMD;
                     r_sclk       <= 1'b0;
                     r_flash_cs_n <= req_sel;
                     r_ram_cs_n   <= !req_sel;
                  end
               end
            end
            ST_CMD, ST_ADDR, ST_DUMMY, ST_DATA: begin
               r_sclk <= !r_sclk;
               if (r_sclk) begin
                  if (!w_last) begin
                     r_cnt <= r_cnt - 8'd1;
                  end else if (r_state == ST_CMD) begin
                     r_state <= ST_ADDR;
                     r_cnt   <= CNT_ADDR;
                  end else if (r_state == ST_ADDR) begin
                     if (r_we || (DUMMY_CYCLES == 0)) begin
                        r_state <= ST_DATA;
                        r_cnt   <= CNT_DATA;
                     end else begin
                        r_state <= ST_DUMMY;
                        r_cnt   <= CNT_DUMMY;
                     end
                  end else if (r_state == ST_DUMMY) begin
                     r_state <= ST_DATA;
                     r_cnt   <= CNT_DATA;
                  end else begin
                     r_state      <= ST_GAP;
                     r_cnt        <= CNT_GAP;
                     r_flash_cs_n <= 1'b1;
                     r_ram_cs_n   <= 1'b1;
                     r_rsp_valid  <= 1'b1;
                     if (!r_we) r_rsp_rdata <= byte_swap({w_shq[27:0], bus_io_in});
                  end
               end
            end
            ST_GAP: begin
               if (w_last) r_state <= ST_IDLE;
               else        r_cnt   <= r_cnt - 8'd1;
            end
            default: r_state <= ST_IDLE;
         endcase
      end
   end

   always_comb begin
      bus_io_out = 4'b0000;
      bus_io_oe  = 4'b0000;
      case (r_state)
         ST_CMD: begin
            bus_io_out = {3'b000, w_shq[31]};
            bus_io_oe  = 4'b0001;
         end
         ST_ADDR: begin
            bus_io_out = w_shq[31:28];
            bus_io_oe  = 4'b1111;
         end
         ST_DATA: begin
            if (r_we) begin
               bus_io_out = w_shq[31:28];
               bus_io_oe  = 4'b1111;
            end
         end
         default: begin
            bus_io_out = 4'b0000;
            bus_io_oe  = 4'b0000;
         end
      endcase
   end

   assign bus_sclk   = r_sclk;
   assign flash_cs_n = r_flash_cs_n;
   assign ram_cs_n   = r_ram_cs_n;
   assign rsp_valid  = r_rsp_valid;
   assign rsp_err    = r_rsp_err;
   assign rsp_rdata  = r_rsp_rdata;

endmodule

// File: tb/tb_qspi_mem_ctrl.sv
// tb/tb_qspi_mem_ctrl.sv - vector table plus scoreboard bench for qspi_mem_ctrl
module tb_qspi_mem_ctrl;

   localparam int DUMMY  = 6;
   localparam int LAT_RD = 2 * (14 + DUMMY + 8) + 1;
   localparam int LAT_WR = 45;
   localparam int NVEC   = 5;

   typedef struct {
      logic        sel;
      logic        we;
      logic [23:0] addr;
      logic [31:0] wdata;
      logic [31:0] mdata;
      logic        err;
      logic [7:0]  cmd;
   } vec_t;

   typedef struct {
      logic        err;
      logic [31:0] rdata;
      int          acc;
      int          lat;
   } exp_t;

   logic        clk;
   logic        rst_n;
   logic        req_valid;
   logic        req_ready;
   logic        req_sel;
   logic        req_we;
   logic [23:0] req_addr;
   logic [31:0] req_wdata;
   logic        rsp_valid;
   logic        rsp_err;
   logic [31:0] rsp_rdata;
   logic        flash_cs_n;
   logic        ram_cs_n;
   logic        bus_sclk;
   logic [3:0]  bus_io_out;
   logic [3:0]  bus_io_oe;
   logic [3:0]  bus_io_in;

   int          n_cmp = 0;
   int          n_fail = 0;
   int          cyc = 0;
   exp_t        sbq[$];
   logic [31:0] last_rd = 32'h0;
   logic [31:0] m_rdata = 32'h0;
   logic [3:0]  cap_io[0:63];
   logic [3:0]  cap_oe[0:63];
   int          cap_n = 0;
   logic        flash_seen = 1'b0;
   logic        ram_seen = 1'b0;
   int          sclk_viol = 0;
   int          rdy_viol = 0;
   int          dual_viol = 0;
   int          hi_run = 0;
   int          last_gap = 0;
   vec_t        vecs[NVEC];

   qspi_mem_ctrl #(.DUMMY_CYCLES(DUMMY)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .req_valid  (req_valid),
      .req_ready  (req_ready),
      .req_sel    (req_sel),
      .req_we     (req_we),
      .req_addr   (req_addr),
      .req_wdata  (req_wdata),
      .rsp_valid  (rsp_valid),
      .rsp_err    (rsp_err),
      .rsp_rdata  (rsp_rdata),
      .flash_cs_n (flash_cs_n),
      .ram_cs_n   (ram_cs_n),
      .bus_sclk   (bus_sclk),
      .bus_io_out (bus_io_out),
      .bus_io_oe  (bus_io_oe),
      .bus_io_in  (bus_io_in)
   );

   initial clk = 1'b0;
   always #5 clk = !clk;
   always @(posedge clk) cyc++;

   function automatic logic [3:0] nib_of(input logic [31:0] w, input int j);
      logic [7:0] b;
      b = w[8 * (j / 2) +: 8];
      return ((j % 2) == 0) ? b[7:4] : b[3:0];
   endfunction

   task automatic check(input string nm, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h", nm, got, exp);
      end
   endtask

   // Memory model: record what the controller drives, return read nibbles after the dummy cycles.
   always @(negedge flash_cs_n or negedge ram_cs_n) cap_n = 0;
   always @(posedge bus_sclk) begin
      int j;
      if (cap_n < 64) begin
         cap_io[cap_n] = bus_io_out;
         cap_oe[cap_n] = bus_io_oe;
      end
      j = cap_n - 14 - DUMMY;
      if (j >= 0 && j < 8) bus_io_in = nib_of(m_rdata, j);
      cap_n++;
   end

   always @(negedge clk) begin
      exp_t e;
      if (rst_n && rsp_valid) begin
         if (sbq.size() == 0) begin
            n_cmp++;
            n_fail++;
            $display("FAIL unexpected_rsp: got rsp_valid=1 at cycle %0d, expected none", cyc);
         end else begin
            e = sbq.pop_front();
            check("rsp_err", {31'b0, rsp_err}, {31'b0, e.err});
            check("rsp_latency", cyc + 1 - e.acc, e.lat);
            check("rsp_rdata", rsp_rdata, e.rdata);
         end
      end
      if (!flash_cs_n) flash_seen = 1'b1;
      if (!ram_cs_n) ram_seen = 1'b1;
      if (flash_cs_n && ram_cs_n && bus_sclk) sclk_viol++;
      if (!flash_cs_n && !ram_cs_n) dual_viol++;
      if ((!flash_cs_n || !ram_cs_n) && req_ready) rdy_viol++;
      if (flash_cs_n && ram_cs_n) hi_run++;
      else begin
         if (hi_run > 0) last_gap = hi_run;
         hi_run = 0;
      end
   end

   // Leaves req_valid high after the accepting edge; the caller decides when to drop it.
   task automatic issue(input logic sel, input logic we, input logic [23:0] addr,
                        input logic [31:0] wdata, input logic err, output int acc);
      int   t;
      exp_t e;
      @(negedge clk);
      req_sel   = sel;
      req_we    = we;
      req_addr  = addr;
      req_wdata = wdata;
      req_valid = 1'b1;
      t = 0;
      while (!req_ready && t < 200) begin
         @(negedge clk);
         t++;
      end
      n_cmp++;
      if (!req_ready) begin
         n_fail++;
         $display("FAIL accept_timeout: got no req_ready in %0d cycles, expected accept", t);
      end
      acc     = cyc + 1;
      e.err   = err;
      e.lat   = err ? 1 : (we ? LAT_WR : LAT_RD);
      e.rdata = (!we && !err) ? m_rdata : last_rd;
      e.acc   = acc;
      last_rd = e.rdata;
      sbq.push_back(e);
      @(posedge clk);
   endtask

   task automatic wait_idle();
      int t;
      t = 0;
      while (sbq.size() != 0 && t < 300) begin
         @(negedge clk);
         t++;
      end
      if (sbq.size() != 0) begin
         n_cmp++;
         n_fail++;
         $display("FAIL rsp_timeout: got %0d pending responses, expected 0", sbq.size());
         sbq.delete();
      end
   endtask

   task automatic run_vec(input vec_t v);
      int          acc;
      int          bad;
      logic [7:0]  c;
      logic [23:0] a;
      logic [31:0] d;
      logic [31:0] dexp;
      flash_seen = 1'b0;
      ram_seen   = 1'b0;
      m_rdata    = v.mdata;
      issue(v.sel, v.we, v.addr, v.wdata, v.err, acc);
      @(negedge clk);
      req_valid = 1'b0;
      wait_idle();
      if (v.err) begin
         check("reject_flash_cs", {31'b0, flash_seen}, 32'd0);
         check("reject_ram_cs", {31'b0, ram_seen}, 32'd0);
      end else begin
         check("flash_cs_used", {31'b0, flash_seen}, {31'b0, !v.sel});
         check("ram_cs_used", {31'b0, ram_seen}, {31'b0, v.sel});
         check("sclk_count", cap_n, v.we ? 22 : 14 + DUMMY + 8);
         c = 8'h0;
         bad = 0;
         for (int k = 0; k < 8; k++) begin
            c = {c[6:0], cap_io[k][0]};
            if (cap_oe[k] !== 4'b0001) bad++;
         end
         check("cmd_byte", {24'b0, c}, {24'b0, v.cmd});
         check("cmd_oe", bad, 0);
         a = 24'h0;
         bad = 0;
         for (int k = 0; k < 6; k++) begin
            a = {a[19:0], cap_io[8 + k]};
            if (cap_oe[8 + k] !== 4'b1111) bad++;
         end
         check("addr_nibbles", {8'b0, a}, {8'b0, v.addr});
         check("addr_oe", bad, 0);
         bad = 0;
         if (v.we) begin
            d = 32'h0;
            dexp = 32'h0;
            for (int k = 0; k < 8; k++) begin
               d    = {d[27:0], cap_io[14 + k]};
               dexp = {dexp[27:0], nib_of(v.wdata, k)};
               if (cap_oe[14 + k] !== 4'b1111) bad++;
            end
            check("wr_data_nibbles", d, dexp);
            check("wr_data_oe", bad, 0);
         end else begin
            for (int k = 14; k < 14 + DUMMY + 8; k++)
               if (cap_oe[k] !== 4'b0000) bad++;
            check("rd_dummy_data_oe", bad, 0);
         end
      end
   endtask

   initial begin
      int acc1;
      int acc2;
      rst_n     = 1'b0;
      req_valid = 1'b0;
      req_sel   = 1'b0;
      req_we    = 1'b0;
      req_addr  = 24'h0;
      req_wdata = 32'h0;
      bus_io_in = 4'h0;

      vecs[0] = '{1'b0, 1'b0, 24'h000100, 32'h0, 32'h44332211, 1'b0, 8'hEB};
      vecs[1] = '{1'b1, 1'b0, 24'hABCDEF, 32'h0, 32'h8A7B6C5D, 1'b0, 8'hEB};
      vecs[2] = '{1'b0, 1'b1, 24'h000020, 32'h12345678, 32'h0, 1'b1, 8'h00};
`ifdef QSPI_PSRAM_WRITE_EN
      vecs[3] = '{1'b1, 1'b1, 24'h000010, 32'hA5B6C7D8, 32'h0, 1'b0, 8'h38};
`else
      vecs[3] = '{1'b1, 1'b1, 24'h000010, 32'hA5B6C7D8, 32'h0, 1'b1, 8'h00};
`endif
      vecs[4] = '{1'b0, 1'b0, 24'hFFFFFF, 32'h0, 32'h0F1E2D3C, 1'b0, 8'hEB};

      repeat (3) @(negedge clk);
      check("reset_outputs",
            {22'b0, flash_cs_n, ram_cs_n, bus_sclk, bus_io_oe, rsp_valid, rsp_err, req_ready},
            {22'b0, 1'b1, 1'b1, 1'b0, 4'b0000, 1'b0, 1'b0, 1'b0});
      check("reset_io_out", {28'b0, bus_io_out}, 32'd0);
      check("reset_rdata", rsp_rdata, 32'd0);
      rst_n = 1'b1;
      #1;
      check("ready_before_edge", {31'b0, req_ready}, 32'd0);
      @(negedge clk);
      check("ready_after_release", {31'b0, req_ready}, 32'd1);

      for (int i = 0; i < NVEC; i++) run_vec(vecs[i]);

      // Back-to-back reads with req_valid held across both transfers.
      m_rdata = 32'hC3D2E1F0;
      issue(1'b0, 1'b0, 24'h000400, 32'h0, 1'b0, acc1);
      issue(1'b1, 1'b0, 24'h000800, 32'h0, 1'b0, acc2);
      @(negedge clk);
      req_valid = 1'b0;
      wait_idle();
      check("b2b_accept_spacing", acc2 - acc1, 2 * (14 + DUMMY + 8) + 2 + 1);
      n_cmp++;
      if (last_gap < 2) begin
         n_fail++;
         $display("FAIL b2b_cs_gap: got %0d clk with both CS high, expected at least 2", last_gap);
      end

      // Asynchronous reset 20 clocks into a read.
      m_rdata = 32'h55AA55AA;
      issue(1'b0, 1'b0, 24'h123456, 32'h0, 1'b0, acc1);
      @(negedge clk);
      req_valid = 1'b0;
      while (cyc < acc1 + 20) @(posedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      sbq.delete();
      check("abort_cs", {30'b0, flash_cs_n, ram_cs_n}, {30'b0, 1'b1, 1'b1});
      check("abort_sclk_oe", {27'b0, bus_sclk, bus_io_oe}, 32'd0);
      check("abort_rsp", {30'b0, rsp_valid, req_ready}, 32'd0);
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      check("abort_ready_after_release", {31'b0, req_ready}, 32'd1);
      last_rd = 32'h0;
      repeat (70) @(negedge clk);
      run_vec(vecs[1]);

      check("sclk_while_cs_high", sclk_viol, 0);
      check("both_cs_low", dual_viol, 0);
      check("ready_outside_idle", rdy_viol, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
